// File: rtl/q16_duty_pwm_pkg.sv
// q16_duty_pwm_pkg: shared Q16.16 constants and duty-to-compare scaling
package q16_duty_pwm_pkg;
    localparam int FRAC_BITS = 16;
    localparam logic [31:0] Q_ONE = 32'h0001_0000;

    // Scale a clamped duty (integer bit + 16 fraction bits) by the period.
    // The 33-bit product cannot overflow; the shift truncates toward zero.
    function automatic logic [15:0] duty_to_cmp(input logic [16:0] duty, input logic [15:0] period);
        logic [32:0] prod;
        prod = {16'b0, duty} * {17'b0, period};
        return prod[FRAC_BITS +: 16];
    endfunction
endpackage

// File: rtl/q16_clamp.sv
// q16_clamp: saturate a signed Q16.16 value to [LO, HI]
//   duty    - signed Q16.16 value to limit
//   clamped - duty limited to [LO, HI]
//   sat     - high when duty lay outside [LO, HI]
module q16_clamp #(
    parameter logic signed [31:0] LO = 32'sh0000_0000,
    parameter logic signed [31:0] HI = 32'sh0000_F333
) (
    input  logic signed [31:0] duty,
    output logic signed [31:0] clamped,
    output logic               sat
);
    always_comb begin
        clamped = duty < LO ? LO : duty > HI ? HI : duty;
        sat = duty < LO || duty > HI;
    end
endmodule

// File: rtl/q16_duty_pwm.sv
// q16_duty_pwm: Q16.16 duty command to complementary PWM with dead-time
//   i_clk, i_reset         - clock, synchronous active-high reset
//   i_duty, i_duty_valid   - signed Q16.16 duty command, accepted every valid cycle
//   o_pwm_hi, o_pwm_lo     - high/low-side gate drives, never both high
//   o_period_start         - high in the cycle the counter is 0
//   o_cmp                  - compare value applied for the current period
//   o_sat                  - last accepted command was clamped
//   o_overrun              - pending compare was replaced before being applied
module q16_duty_pwm
    import q16_duty_pwm_pkg::*;
#(
    parameter int unsigned        PERIOD   = 1000,
    parameter int unsigned        DEADTIME = 10,
    parameter logic signed [31:0] DMIN     = 32'sh0000_0000,
    parameter logic signed [31:0] DMAX     = 32'sh0000_F333
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic signed [31:0] i_duty,
    input  logic               i_duty_valid,
    output logic               o_pwm_hi,
    output logic               o_pwm_lo,
    output logic               o_period_start,
    output logic [15:0]        o_cmp,
    output logic               o_sat,
    output logic               o_overrun
);
    // Keep the upper clamp strictly below 1.0 so d[16:0] is the whole duty.
    localparam logic signed [31:0] HI = DMAX < $signed(Q_ONE) ? DMAX : $signed(Q_ONE - 32'd1);

    logic signed [31:0] clamped;
    logic               sat;
    logic [16:0]        d1;
    logic               v1;
    logic [15:0]        cnt;
    logic [15:0]        pend_cmp;
    logic               pend;
    logic               wrap;

    q16_clamp #(.LO(DMIN), .HI(HI)) u_clamp (
        .duty   (i_duty),
        .clamped(clamped),
        .sat    (sat)
    );

    assign wrap = cnt == 16'(PERIOD - 1);
    assign o_period_start = !i_reset && cnt == '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            d1        <= '0;
            v1        <= 1'b0;
            o_sat     <= 1'b0;
            cnt       <= '0;
            pend_cmp  <= '0;
            pend      <= 1'b0;
            o_cmp     <= '0;
            o_overrun <= 1'b0;
            o_pwm_hi  <= 1'b0;
            o_pwm_lo  <= 1'b0;
        end else begin
            v1 <= i_duty_valid;
            if (i_duty_valid) begin
                d1    <= 17'(clamped);
                o_sat <= sat;
            end
            cnt <= wrap ? '0 : cnt + 16'd1;
            // On a write coinciding with the wrap, the old pending value is
            // applied and the new one stays pending for the next period.
            if (wrap && pend) o_cmp <= pend_cmp;
            if (v1) pend_cmp <= duty_to_cmp(d1, 16'(PERIOD));
            pend      <= v1 || (pend && !wrap);
            o_overrun <= v1 && pend && !wrap;
            o_pwm_hi  <= cnt >= 16'(DEADTIME) && cnt < o_cmp;
            o_pwm_lo  <= {1'b0, cnt} >= {1'b0, o_cmp} + 17'(DEADTIME);
        end
    end
endmodule
